// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the memory access controller.
package lc3_mem_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter: clear, count-enable and terminal-count compare.
module mem_wait_counter
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Terminal count reached when the count equals the configured wait cycles.
    always_comb begin
        tc_o = (count_q == CNT_W'(WAIT_CYCLES));
    end

    // Next count: clear wins; hold at terminal count so it never wraps.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR register pair with a fixed-latency memory access sequencer.
module mem_access_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [WORD_W-1:0] bus_i,
    input  logic              ld_mar_i,
    input  logic              ld_mdr_i,
    input  logic              req_rd_i,
    input  logic              req_wr_i,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic [WORD_W-1:0] mar_o,
    output logic [WORD_W-1:0] mdr_o,
    output logic [WORD_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic              mem_ce_no,
    output logic              mem_oe_no,
    output logic              mem_we_no,
    output logic              ready_o,
    output logic              busy_o
);

    mem_state_e        state_q;
    logic [WORD_W-1:0] mar_q;
    logic [WORD_W-1:0] mdr_q;
    logic              is_rd_q;
    logic              ce_n_q;
    logic              oe_n_q;
    logic              we_n_q;
    logic              ready_q;

    logic              start;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;

    // Request decode and wait counter control.
    always_comb begin
        start   = (state_q == IDLE) && (req_rd_i || req_wr_i);
        cnt_clr = start;
        cnt_en  = (state_q == ACCESS);
    end

    mem_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    // Sequencer with registered strobes; register loads only accepted in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            is_rd_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (ld_mar_i) begin
                        mar_q <= bus_i;
                    end
                    if (ld_mdr_i) begin
                        mdr_q <= bus_i;
                    end
                    if (req_rd_i || req_wr_i) begin
                        // Write wins when both requests arrive together.
                        state_q <= ACCESS;
                        is_rd_q <= ~req_wr_i;
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= req_wr_i;
                        we_n_q  <= ~req_wr_i;
                    end
                end
                ACCESS: begin
                    if (cnt_tc) begin
                        state_q <= DONE;
                        if (is_rd_q) begin
                            mdr_q <= mem_rdata_i;
                        end
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs: registers drive the memory port directly.
    always_comb begin
        mar_o       = mar_q;
        mdr_o       = mdr_q;
        mem_addr_o  = mar_q;
        mem_wdata_o = mdr_q;
        mem_ce_no   = ce_n_q;
        mem_oe_no   = oe_n_q;
        mem_we_no   = we_n_q;
        ready_o     = ready_q;
        busy_o      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: default build plus a zero-wait build.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] bus;
    logic        ld_mar, ld_mdr, req_rd, req_wr;
    logic [15:0] rdata;

    logic [15:0] mar, mdr, addr, wdata;
    logic        ce_n, oe_n, we_n, ready, busy;
    logic [15:0] mar0, mdr0, addr0, wdata0;
    logic        ce_n0, oe_n0, we_n0, ready0, busy0;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;

    mem_access_ctrl #(.WAIT_CYCLES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus_i(bus), .ld_mar_i(ld_mar), .ld_mdr_i(ld_mdr),
        .req_rd_i(req_rd), .req_wr_i(req_wr), .mem_rdata_i(rdata),
        .mar_o(mar), .mdr_o(mdr), .mem_addr_o(addr), .mem_wdata_o(wdata),
        .mem_ce_no(ce_n), .mem_oe_no(oe_n), .mem_we_no(we_n), .ready_o(ready), .busy_o(busy)
    );

    mem_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus_i(bus), .ld_mar_i(ld_mar), .ld_mdr_i(ld_mdr),
        .req_rd_i(req_rd), .req_wr_i(req_wr), .mem_rdata_i(rdata),
        .mar_o(mar0), .mdr_o(mdr0), .mem_addr_o(addr0), .mem_wdata_o(wdata0),
        .mem_ce_no(ce_n0), .mem_oe_no(oe_n0), .mem_we_no(we_n0), .ready_o(ready0),
        .busy_o(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_mar = 0; ld_mdr = 0; req_rd = 0; req_wr = 0;
    endtask

    initial begin
        rst_n = 0; bus = 0; rdata = 0;
        idle_inputs();
        #12;
        check_eq("rst_ready", {15'd0, ready}, 16'd0);
        check_eq("rst_busy", {15'd0, busy}, 16'd0);
        check_eq("rst_strobes", {13'd0, ce_n, oe_n, we_n}, 16'h0007);
        check_eq("rst_mar", mar, 16'h0000);
        check_eq("rst_mdr", mdr, 16'h0000);
        tick();
        rst_n = 1;
        tick();

        // Write 0xBEEF to 0x3000.
        ld_mar = 1; bus = 16'h3000; tick();
        ld_mar = 0; ld_mdr = 1; bus = 16'hBEEF; tick();
        ld_mdr = 0; req_wr = 1; tick();
        req_wr = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("wr_strobes%0d", i), {13'd0, ce_n, oe_n, we_n}, 16'h0002);
            check_eq($sformatf("wr_addr%0d", i), addr, 16'h3000);
            check_eq($sformatf("wr_wdata%0d", i), wdata, 16'hBEEF);
            check_eq($sformatf("wr_busy%0d", i), {14'd0, busy, ready}, 16'h0002);
            tick();
        end
        check_eq("wr_done", {12'd0, ce_n, oe_n, we_n, ready}, 16'h000F);
        tick();
        check_eq("wr_idle", {14'd0, busy, ready}, 16'h0000);

        // Read 0x1234 from 0x3000.
        rdata = 16'h1234; req_rd = 1; tick();
        req_rd = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rd_strobes%0d", i), {13'd0, ce_n, oe_n, we_n}, 16'h0001);
            check_eq($sformatf("rd_mdr_hold%0d", i), mdr, 16'hBEEF);
            tick();
        end
        check_eq("rd_ready", {15'd0, ready}, 16'd1);
        check_eq("rd_mdr", mdr, 16'h1234);
        tick();

        // Simultaneous requests: write wins, MDR untouched.
        req_rd = 1; req_wr = 1; tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("both_strobes%0d", i), {13'd0, ce_n, oe_n, we_n}, 16'h0002);
            tick();
        end
        check_eq("both_ready", {15'd0, ready}, 16'd1);
        check_eq("both_mdr", mdr, 16'h1234);
        tick();

        // Load on the request edge is used by the access.
        ld_mar = 1; bus = 16'h4000; req_wr = 1; tick();
        idle_inputs();
        check_eq("ldreq_addr", addr, 16'h4000);
        check_eq("ldreq_we", {15'd0, we_n}, 16'd0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("ldreq_idle", {15'd0, busy}, 16'd0);

        // Loads and requests during ACCESS are ignored; exactly one Ready.
        ld_mar = 1; bus = 16'h3000; req_rd = 1; tick();
        idle_inputs();
        pulses = 0;
        tick();
        ld_mar = 1; bus = 16'hFFFF; req_rd = 1; tick();
        idle_inputs();
        check_eq("ign_mar", mar, 16'h3000);
        for (int i = 0; i < 8; i++) begin
            if (ready) pulses++;
            tick();
        end
        check_eq("ign_pulses", pulses[15:0], 16'd1);
        check_eq("ign_mar_end", mar, 16'h3000);

        // Reset in the second ACCESS cycle of a read.
        rdata = 16'h5A5A; req_rd = 1; tick();
        req_rd = 0; tick();
        check_eq("abort_pre_oe", {15'd0, oe_n}, 16'd0);
        #2 rst_n = 0; #1;
        check_eq("abort_strobes", {13'd0, ce_n, oe_n, we_n}, 16'h0007);
        check_eq("abort_mdr", mdr, 16'h0000);
        check_eq("abort_busy", {14'd0, busy, ready}, 16'h0000);
        tick(); tick();
        rst_n = 1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (ready) pulses++;
            tick();
        end
        check_eq("abort_no_ready", pulses[15:0], 16'd0);
        check_eq("abort_mdr_end", mdr, 16'h0000);

        // Zero-wait build: one ACCESS cycle, held request repeats every 3 cycles.
        rdata = 16'h00C3; req_rd = 1; tick();
        check_eq("w0_access", {13'd0, ce_n0, oe_n0, we_n0}, 16'h0001);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("w0_ready%0d", i), {15'd0, ready0}, (i % 3 == 1) ? 16'd1 : 16'd0);
            check_eq($sformatf("w0_oe%0d", i), {15'd0, oe_n0}, (i % 3 == 0) ? 16'd0 : 16'd1);
        end
        req_rd = 0;
        check_eq("w0_mdr", mdr0, 16'h00C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001: Parameter WAIT_CYCLES, default 2, SHALL set the number of extra memory wait cycles per access (legal 0..15).
REQ-002: Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003: Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004: Bus  input  16  SHALL be the datapath bus value to load into MAR or MDR.
REQ-005: LD_MAR  input  1  SHALL request a load of MAR from Bus.
REQ-006: LD_MDR  input  1  SHALL request a load of MDR from Bus.
REQ-007: Req_Rd  input  1  SHALL request a memory read at the MAR address into MDR.
REQ-008: Req_Wr  input  1  SHALL request a memory write of MDR to the MAR address.
REQ-009: Mem_Rdata  input  16  SHALL carry read data from memory.
REQ-010: MAR  output  16  SHALL be the current address register.
REQ-011: MDR  output  16  SHALL be the current data register, gated onto the bus elsewhere.
REQ-012: Mem_Addr  output  16  SHALL be the memory address.
REQ-013: Mem_Wdata  output  16  SHALL be the memory write data.
REQ-014: Mem_CE_n, Mem_OE_n, Mem_WE_n  outputs  1 each  SHALL be active-low chip enable, output enable and write enable.
REQ-015: Ready  output  1  SHALL be a one-cycle completion pulse.
REQ-016: Busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-017: The state machine SHALL have states IDLE, ACCESS and DONE.
REQ-018: In IDLE, LD_MAR SHALL load MAR<=Bus and LD_MDR SHALL load MDR<=Bus on the same edge; both loads MAY occur together.
REQ-019: LD_MAR and LD_MDR SHALL be ignored while Busy=1.
REQ-020: In IDLE, Req_Wr=1 SHALL start a write and Req_Rd=1 SHALL start a read; if both are asserted, the write SHALL take priority.
REQ-021: A request edge SHALL move IDLE->ACCESS and clear the wait counter to 0; any LD_MAR or LD_MDR on that same edge SHALL also apply, and the access SHALL use the newly loaded values.
REQ-022: ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, with the counter incrementing each cycle; when counter=WAIT_CYCLES it SHALL go to DONE.
REQ-023: During ACCESS: Mem_CE_n=0; Mem_OE_n=0 for a read else 1; Mem_WE_n=0 for a write else 1.
REQ-024: On the ACCESS->DONE edge of a read, MDR SHALL capture Mem_Rdata.
REQ-025: DONE SHALL last one cycle with Ready=1 and all strobes high, then return to IDLE.
REQ-026: Latency SHALL be fixed: with the request sampled at edge E, Ready SHALL be high between edges E+WAIT_CYCLES+1 and E+WAIT_CYCLES+2.
REQ-027: Req_Rd and Req_Wr SHALL be ignored, not queued, in ACCESS and DONE; a new access needs the request held or re-asserted in IDLE.
REQ-028: Mem_Addr SHALL equal MAR and Mem_Wdata SHALL equal MDR at all times; MAR and MDR SHALL be stable throughout ACCESS.
REQ-029: Outside ACCESS, Mem_CE_n, Mem_OE_n and Mem_WE_n SHALL all be 1; Mem_OE_n and Mem_WE_n SHALL never both be 0.
REQ-030: All strobe and Ready outputs SHALL be registered or decoded from state only, with no combinational path from Req_Rd or Req_Wr.

Reset
REQ-031: When Reset_n=0, reset SHALL take effect immediately, independent of Clk: state=IDLE, counter=0, MAR=0, MDR=0.
REQ-032: During reset the outputs SHALL be Ready=0, Busy=0 and Mem_CE_n=Mem_OE_n=Mem_WE_n=1.
REQ-033: Reset asserted mid-ACCESS SHALL abort the access with no MDR update, and no Ready pulse SHALL follow.

Structure
REQ-034: Package lc3_mem_pkg SHALL hold the state enum type (IDLE, ACCESS, DONE) and constant WORD_W=16.
REQ-035: The wait counter SHALL be sub-module mem_wait_counter: 4-bit, with clear, enable and terminal-count compare against WAIT_CYCLES.

Verification
REQ-036: Reset, then LD_MAR with Bus=16'h3000 and LD_MDR with Bus=16'hBEEF, then Req_Wr for 1 cycle -> Mem_WE_n=0 for 3 cycles with Mem_Addr=3000 and Mem_Wdata=BEEF, then Ready=1 for 1 cycle.
REQ-037: MAR=16'h3000, Req_Rd with Mem_Rdata=16'h1234 -> MDR=1234 on the edge Ready rises; Mem_OE_n=0 for 3 cycles; Mem_WE_n stays 1.
REQ-038: Req_Rd=Req_Wr=1 together -> write performed, Mem_OE_n stays 1.
REQ-039: LD_MAR with Bus=16'hFFFF and Req_Rd pulsed during ACCESS -> MAR unchanged and exactly one Ready pulse.
REQ-040: Reset_n low in the 2nd ACCESS cycle of a read -> strobes high immediately, MDR=0, Busy=0, no Ready.
REQ-041: WAIT_CYCLES=0 build: Req_Rd -> one ACCESS cycle and Ready 2 edges after the request; back-to-back held Req_Rd -> a new access every 3 cycles.
